// File: rtl/umem_arb_pkg.sv
// umem_arb_pkg: shared types for the unified-memory arbiter.
// FSM state enum, access-size mask codes and the alignment check.
package umem_arb_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_I_RD,
        S_I_RSP,
        S_D_RD,
        S_D_RSP,
        S_D_WR,
        S_RMW_RD,
        S_RMW_WR,
        S_D_ERR
    } state_e;

    localparam logic [1:0] MASK_B = 2'b00;
    localparam logic [1:0] MASK_H = 2'b01;
    localparam logic [1:0] MASK_W = 2'b10;

    // Illegal size code, odd halfword or non-word-aligned word.
    function automatic logic misaligned(
        input logic [1:0] mask,
        input logic [1:0] lo
    );
        logic bad;
        bad = 1'b0;
        if (mask == 2'b11) begin
            bad = 1'b1;
        end else if (mask == MASK_H) begin
            bad = lo[0];
        end else if (mask == MASK_W) begin
            bad = (lo != 2'b00);
        end
        return bad;
    endfunction

endpackage

// File: rtl/umem_arbiter_if.sv
// umem_arbiter_if: fetch port, data port and memory-macro signals.
// slave = arbiter side, master = requesters + memory (testbench).
interface umem_arbiter_if #(
    parameter int ADDR_W = 32
);

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_rdata;
    logic              i_done;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [1:0]        d_mask;
    logic              d_sext;
    logic [31:0]       d_rdata;
    logic              d_done;
    logic              d_err;

    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic              m_we;
    logic [31:0]       m_rdata;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata, d_mask, d_sext,
        input  m_rdata,
        output i_rdata, i_done,
        output d_rdata, d_done, d_err,
        output m_addr, m_wdata, m_we
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata, d_mask, d_sext,
        output m_rdata,
        input  i_rdata, i_done,
        input  d_rdata, d_done, d_err,
        input  m_addr, m_wdata, m_we
    );

endinterface

// File: rtl/umem_lane_fmt.sv
// umem_lane_fmt: load lane extract/sign-extend and store lane merge.
// Ports: word_i (memory word), addr_lo_i, mask_i, sext_i, wdata_i -> load_o, store_o.
module umem_lane_fmt
    import umem_arb_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  mask_i,
    input  logic        sext_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);

    logic [4:0]  b_off;
    logic [4:0]  h_off;
    logic [7:0]  b;
    logic [15:0] h;

    assign b_off = {addr_lo_i, 3'b000};
    assign h_off = {addr_lo_i[1], 4'b0000};

    always_comb begin
        b       = word_i[b_off +: 8];
        h       = word_i[h_off +: 16];
        load_o  = word_i;
        store_o = wdata_i;
        unique case (1'b1)
            (mask_i == MASK_B): begin
                load_o  = {{24{sext_i & b[7]}}, b};
                store_o = word_i;
                store_o[b_off +: 8] = wdata_i[7:0];
            end
            (mask_i == MASK_H): begin
                load_o  = {{16{sext_i & h[15]}}, h};
                store_o = word_i;
                store_o[h_off +: 16] = wdata_i[15:0];
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/umem_arbiter.sv
// umem_arbiter: shares one sync-read memory between fetch and data ports.
// Ports: clk, reset (async, active-low), bus (umem_arbiter_if.slave). Option: UMEM_ARB_RR_EN.
module umem_arbiter
    import umem_arb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    umem_arbiter_if.slave  bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        mask_q, mask_d;
    logic              sext_q, sext_d;
    logic              we_q, we_d;
    logic              grant_d;
    logic              grant_i;
    logic [31:0]       load_w;
    logic [31:0]       store_w;

`ifdef UMEM_ARB_RR_EN
    // 1 = data port holds priority on the next contention.
    logic rr_q, rr_d;
`endif

    umem_lane_fmt u_fmt (
        .word_i    (bus.m_rdata),
        .addr_lo_i (addr_q[1:0]),
        .mask_i    (mask_q),
        .sext_i    (sext_q),
        .wdata_i   (wdata_q),
        .load_o    (load_w),
        .store_o   (store_w)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            sext_q  <= 1'b0;
            we_q    <= 1'b0;
`ifdef UMEM_ARB_RR_EN
            rr_q    <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            sext_q  <= sext_d;
            we_q    <= we_d;
`ifdef UMEM_ARB_RR_EN
            rr_q    <= rr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        sext_d  = sext_q;
        we_d    = we_q;
`ifdef UMEM_ARB_RR_EN
        rr_d    = rr_q;
        grant_d = bus.d_req & (~bus.i_req | rr_q);
        grant_i = bus.i_req & ~grant_d;
`else
        grant_d = bus.d_req;
        grant_i = bus.i_req & ~bus.d_req;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (grant_d) begin
                    addr_d  = bus.d_addr;
                    wdata_d = bus.d_wdata;
                    mask_d  = bus.d_mask;
                    sext_d  = bus.d_sext;
                    we_d    = bus.d_we;
`ifdef UMEM_ARB_RR_EN
                    rr_d    = 1'b0;
`endif
                    if (misaligned(bus.d_mask, bus.d_addr[1:0])) begin
                        state_d = S_D_ERR;
                    end else if (!bus.d_we) begin
                        state_d = S_D_RD;
                    end else if (bus.d_mask == MASK_W) begin
                        state_d = S_D_WR;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end else if (grant_i) begin
                    addr_d  = bus.i_addr;
                    wdata_d = '0;
                    mask_d  = MASK_W;
                    sext_d  = 1'b0;
                    we_d    = 1'b0;
`ifdef UMEM_ARB_RR_EN
                    rr_d    = 1'b1;
`endif
                    state_d = S_I_RD;
                end
            end
            S_I_RD:   state_d = S_I_RSP;
            S_I_RSP:  state_d = S_IDLE;
            S_D_RD:   state_d = S_D_RSP;
            S_D_RSP:  state_d = S_IDLE;
            S_D_WR:   state_d = S_IDLE;
            S_RMW_RD: state_d = S_RMW_WR;
            S_RMW_WR: state_d = S_IDLE;
            S_D_ERR:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // All outputs decode from registered state only.
    always_comb begin
        bus.i_rdata = '0;
        bus.i_done  = 1'b0;
        bus.d_rdata = '0;
        bus.d_done  = 1'b0;
        bus.d_err   = 1'b0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.m_we    = 1'b0;
        unique case (state_q)
            S_I_RD, S_D_RD, S_RMW_RD: begin
                bus.m_addr = {addr_q[ADDR_W-1:2], 2'b00};
            end
            S_I_RSP: begin
                bus.i_done  = 1'b1;
                bus.i_rdata = bus.m_rdata;
            end
            S_D_RSP: begin
                bus.d_done  = 1'b1;
                bus.d_rdata = load_w;
            end
            S_D_WR, S_RMW_WR: begin
                // m_rdata still holds the word read in RMW_RD.
                bus.m_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                bus.m_we    = we_q;
                bus.m_wdata = store_w;
                bus.d_done  = 1'b1;
            end
            S_D_ERR: begin
                bus.d_done = 1'b1;
                bus.d_err  = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_umem_arbiter.sv
// tb_umem_arbiter: directed vector bench for umem_arbiter.
// Behavioural sync-read memory model drives m_rdata.
module tb_umem_arbiter;

    logic clk;
    logic reset;

    umem_arbiter_if #(.ADDR_W(32)) bus ();

    umem_arbiter #(.ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    logic [31:0] mem_rd_q;
    logic [7:0]  mem_idx;

    assign mem_idx     = bus.m_addr[9:2];
    assign bus.m_rdata = mem_rd_q;

    always @(posedge clk) begin
        mem_rd_q <= mem[mem_idx];
        if (bus.m_we) mem[mem_idx] = bus.m_wdata;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [131:0] all_outs();
        return {bus.i_rdata, bus.i_done, bus.d_rdata, bus.d_done, bus.d_err,
                bus.m_addr, bus.m_wdata, bus.m_we};
    endfunction

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  mask;
        logic        sext;
        logic [31:0] init;
        int          lat;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] mem;
    } vec_t;

    vec_t vt[14];

    task automatic do_data(input vec_t v, output int lat, output logic [31:0] rd,
                           output logic err, output logic we_seen);
        bus.d_we    = v.we;
        bus.d_addr  = v.addr;
        bus.d_wdata = v.wdata;
        bus.d_mask  = v.mask;
        bus.d_sext  = v.sext;
        bus.d_req   = 1'b1;
        lat = -1; rd = '0; err = 1'b0; we_seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.m_we) we_seen = 1'b1;
            if (bus.d_done) begin
                lat = n; rd = bus.d_rdata; err = bus.d_err;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.d_req = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] a, output int lat,
                            output logic [31:0] rd, output logic we_seen);
        bus.i_addr = a;
        bus.i_req  = 1'b1;
        lat = -1; rd = '0; we_seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.m_we) we_seen = 1'b1;
            if (bus.i_done) begin
                lat = n; rd = bus.i_rdata;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.i_req = 1'b0;
    endtask

    task automatic contend(output int dc, output int ic,
                           output logic [31:0] drd, output logic [31:0] ird);
        bus.i_addr  = 32'h40;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h100;
        bus.d_mask  = 2'b10;
        bus.d_sext  = 1'b0;
        bus.i_req   = 1'b1;
        bus.d_req   = 1'b1;
        dc = -1; ic = -1; drd = '0; ird = '0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (bus.d_done) begin dc = n; drd = bus.d_rdata; end
            if (bus.i_done) begin ic = n; ird = bus.i_rdata; end
            @(posedge clk); #1;
            if (dc == n) bus.d_req = 1'b0;
            if (ic == n) bus.i_req = 1'b0;
            if (dc >= 0 && ic >= 0) break;
        end
        bus.d_req = 1'b0;
        bus.i_req = 1'b0;
    endtask

    int          lat, dc, ic;
    logic [31:0] rd, drd, ird;
    logic        err, we_seen;
    int          exp_dc, exp_ic;

    initial begin
        vt[0]  = '{0, 32'h102, 32'h0, 2'b00, 1, 32'h80FF7F01, 2, 0, 32'hFFFFFFFF, 32'h80FF7F01};
        vt[1]  = '{0, 32'h102, 32'h0, 2'b00, 0, 32'h80FF7F01, 2, 0, 32'h000000FF, 32'h80FF7F01};
        vt[2]  = '{0, 32'h103, 32'h0, 2'b00, 1, 32'h80FF7F01, 2, 0, 32'hFFFFFF80, 32'h80FF7F01};
        vt[3]  = '{0, 32'h100, 32'h0, 2'b00, 1, 32'h80FF7F01, 2, 0, 32'h00000001, 32'h80FF7F01};
        vt[4]  = '{0, 32'h102, 32'h0, 2'b01, 1, 32'h80FF7F01, 2, 0, 32'hFFFF80FF, 32'h80FF7F01};
        vt[5]  = '{0, 32'h100, 32'h0, 2'b01, 1, 32'h80FF7F01, 2, 0, 32'h00007F01, 32'h80FF7F01};
        vt[6]  = '{0, 32'h100, 32'h0, 2'b10, 1, 32'h80FF7F01, 2, 0, 32'h80FF7F01, 32'h80FF7F01};
        vt[7]  = '{1, 32'h202, 32'h00001234, 2'b01, 0, 32'hAABBCCDD, 2, 0, 32'h0, 32'h1234CCDD};
        vt[8]  = '{1, 32'h201, 32'h00000055, 2'b00, 0, 32'h1234CCDD, 2, 0, 32'h0, 32'h123455DD};
        vt[9]  = '{1, 32'h204, 32'hCAFEBABE, 2'b10, 0, 32'h00000000, 1, 0, 32'h0, 32'hCAFEBABE};
        vt[10] = '{1, 32'h206, 32'hDEADBEEF, 2'b10, 0, 32'h01020304, 1, 1, 32'h0, 32'h01020304};
        vt[11] = '{0, 32'h101, 32'h0, 2'b01, 0, 32'h80FF7F01, 1, 1, 32'h0, 32'h80FF7F01};
        vt[12] = '{0, 32'h100, 32'h0, 2'b11, 0, 32'h80FF7F01, 1, 1, 32'h0, 32'h80FF7F01};
        vt[13] = '{1, 32'h20B, 32'hFFFFFFAB, 2'b00, 0, 32'h11111111, 2, 0, 32'h0, 32'hAB111111};

        for (int i = 0; i < 256; i++) mem[i] = '0;
        bus.i_req = 0; bus.i_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0;
        bus.d_wdata = '0; bus.d_mask = '0; bus.d_sext = 0;
        reset = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", all_outs(), '0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        mem[8'h10] = 32'h11223344;
        mem[8'h40] = 32'h80FF7F01;

        // Two contention rounds: pointer starts at data, so data first in both builds.
        for (int r = 0; r < 2; r++) begin
            contend(dc, ic, drd, ird);
            chk($sformatf("cont%0d_dlat", r), dc, 2);
            chk($sformatf("cont%0d_ilat", r), ic, 5);
            chk($sformatf("cont%0d_drd", r), drd, 32'h80FF7F01);
            chk($sformatf("cont%0d_ird", r), ird, 32'h11223344);
        end

        do_fetch(32'h40, lat, rd, we_seen);
        chk("fetch_lat", lat, 2);
        chk("fetch_rdata", rd, 32'h11223344);
        chk("fetch_no_we", we_seen, 0);

        for (int i = 0; i < 14; i++) begin
            mem[vt[i].addr[9:2]] = vt[i].init;
            do_data(vt[i], lat, rd, err, we_seen);
            chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
            chk($sformatf("v%0d_err", i), err, vt[i].err);
            chk($sformatf("v%0d_mem", i), mem[vt[i].addr[9:2]], vt[i].mem);
            if (!vt[i].we) chk($sformatf("v%0d_rdata", i), rd, vt[i].rdata);
            if (!vt[i].we || vt[i].err) chk($sformatf("v%0d_no_we", i), we_seen, 0);
        end

        // Last grant was data: round-robin now favours fetch.
        mem[8'h40] = 32'h80FF7F01;
`ifdef UMEM_ARB_RR_EN
        exp_dc = 5; exp_ic = 2;
`else
        exp_dc = 2; exp_ic = 5;
`endif
        contend(dc, ic, drd, ird);
        chk("cont2_dlat", dc, exp_dc);
        chk("cont2_ilat", ic, exp_ic);

        // Reset asserted while in RMW_RD.
        mem[8'h84] = 32'h76543210;
        bus.d_we = 1; bus.d_addr = 32'h211; bus.d_wdata = 32'hEE;
        bus.d_mask = 2'b00; bus.d_sext = 0; bus.d_req = 1;
        @(posedge clk); #1;
        chk("rmw_rd_addr", bus.m_addr, 32'h210);
        reset = 1'b0;
        #1;
        chk("rmw_reset_outs", all_outs(), '0);
        bus.d_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rmw_reset_mem", mem[8'h84], 32'h76543210);
        do_fetch(32'h40, lat, rd, we_seen);
        chk("post_rst_fetch_lat", lat, 2);
        chk("post_rst_fetch_rdata", rd, 32'h11223344);
        chk("post_rst_mem", mem[8'h84], 32'h76543210);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
